// File: rtl/uart_host_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_host_master
// Brief    : Register-bus initiator for a 16550 register file. Programs the
//            divisor (through DLAB), LCR, FCR and IER after a start request,
//            then polls LSR and moves bytes between RBR/THR and two
//            valid/ready streams.
// Revision : 1.0 - initial release
// ============================================================================
module uart_host_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] divisor,
  input  logic [7:0]  lcr_cfg,
  input  logic [7:0]  fcr_cfg,
  input  logic [7:0]  ier_cfg,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  input  logic        rx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        cs,
  output logic        wr,
  output logic        rd,
  output logic [2:0]  addr,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata,
  output logic        cfg_done
);

  // 16550 register offsets used by this initiator
  localparam logic [2:0] ADDR_DATA = 3'd0;  // RBR / THR / DLL
  localparam logic [2:0] ADDR_IER  = 3'd1;  // IER / DLM
  localparam logic [2:0] ADDR_FCR  = 3'd2;
  localparam logic [2:0] ADDR_LCR  = 3'd3;
  localparam logic [2:0] ADDR_LSR  = 3'd5;
  localparam int         LSR_DR    = 0;
  localparam int         LSR_THRE  = 5;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CFG0    = 4'd1,
    CFG1    = 4'd2,
    CFG2    = 4'd3,
    CFG3    = 4'd4,
    CFG4    = 4'd5,
    CFG5    = 4'd6,
    RUN_LSR = 4'd7,
    RUN_RBR = 4'd8,
    RUN_THR = 4'd9,
    GAP     = 4'd10
  } state_t;

  state_t      state, state_d;
  state_t      gap_next, gap_next_d;  // where a non-poll gap continues
  logic        poll_gap, poll_gap_d;  // gap follows an LSR read: make a decision
  logic [7:0]  lsr_q;
  logic [15:0] div_q;
  logic [6:0]  lcr_q;                 // bit7 is forced per write, never stored
  logic [7:0]  fcr_q;
  logic [7:0]  ier_q;
  logic        accept_start;
  logic        take_tx;
  logic [6:0]  lcr_src;
  logic        cs_d;
  logic        wr_d;
  logic [2:0]  addr_d;
  logic [7:0]  wdata_d;
  logic        unused_bits;

  // Only DR and THRE steer the poll loop; LCR bit7 is supplied by the sequence.
  assign unused_bits = ^{lsr_q[7:6], lsr_q[4:1], lcr_cfg[7]};

  // Next-state logic: every access state is followed by one GAP cycle
  always_comb begin
    state_d      = state;
    gap_next_d   = gap_next;
    poll_gap_d   = poll_gap;
    accept_start = 1'b0;
    take_tx      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d      = CFG0;
          accept_start = 1'b1;
        end
      end
      CFG0:    begin state_d = GAP; gap_next_d = CFG1;    poll_gap_d = 1'b0; end
      CFG1:    begin state_d = GAP; gap_next_d = CFG2;    poll_gap_d = 1'b0; end
      CFG2:    begin state_d = GAP; gap_next_d = CFG3;    poll_gap_d = 1'b0; end
      CFG3:    begin state_d = GAP; gap_next_d = CFG4;    poll_gap_d = 1'b0; end
      CFG4:    begin state_d = GAP; gap_next_d = CFG5;    poll_gap_d = 1'b0; end
      CFG5:    begin state_d = GAP; gap_next_d = RUN_LSR; poll_gap_d = 1'b0; end
      RUN_LSR: begin state_d = GAP; gap_next_d = RUN_LSR; poll_gap_d = 1'b1; end
      RUN_RBR,
      RUN_THR: begin state_d = GAP; gap_next_d = RUN_LSR; poll_gap_d = 1'b0; end
      GAP: begin
        if (poll_gap) begin
          // Restart beats RX, RX beats TX; a data access always needs a fresh poll.
          if (start) begin
            state_d      = CFG0;
            accept_start = 1'b1;
          end else if (lsr_q[LSR_DR] && rx_ready) begin
            state_d = RUN_RBR;
          end else if (lsr_q[LSR_THRE] && tx_valid) begin
            state_d = RUN_THR;
            take_tx = 1'b1;
          end else begin
            state_d = RUN_LSR;
          end
        end else begin
          state_d = gap_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus values for the cycle being entered; CFG0 can follow start directly,
  // so it takes LCR from the input while the capture register is loading.
  always_comb begin
    lcr_src = accept_start ? lcr_cfg[6:0] : lcr_q;
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = 3'd0;
    wdata_d = 8'h00;
    unique case (state_d)
      CFG0:    begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_LCR;  wdata_d = {1'b1, lcr_src}; end
      CFG1:    begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_DATA; wdata_d = div_q[7:0];      end
      CFG2:    begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_IER;  wdata_d = div_q[15:8];     end
      CFG3:    begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_LCR;  wdata_d = {1'b0, lcr_q};   end
      CFG4:    begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_FCR;  wdata_d = fcr_q;           end
      CFG5:    begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_IER;  wdata_d = ier_q;           end
      RUN_LSR: begin cs_d = 1'b1; addr_d = ADDR_LSR;  end
      RUN_RBR: begin cs_d = 1'b1; addr_d = ADDR_DATA; end
      // RUN_THR is entered only on the handshake edge, so tx_data is the byte taken
      RUN_THR: begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_DATA; wdata_d = tx_data;   end
      default: ;
    endcase
  end

  assign tx_ready = take_tx & ~rst;

  // State, capture and bus registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gap_next <= IDLE;
      poll_gap <= 1'b0;
      lsr_q    <= 8'h00;
      div_q    <= 16'h0000;
      lcr_q    <= 7'h00;
      fcr_q    <= 8'h00;
      ier_q    <= 8'h00;
      cs       <= 1'b0;
      wr       <= 1'b0;
      rd       <= 1'b0;
      addr     <= 3'd0;
      wdata    <= 8'h00;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      cfg_done <= 1'b0;
    end else begin
      state    <= state_d;
      gap_next <= gap_next_d;
      poll_gap <= poll_gap_d;
      if (accept_start) begin
        div_q <= divisor;
        lcr_q <= lcr_cfg[6:0];
        fcr_q <= fcr_cfg;
        ier_q <= ier_cfg;
      end
      if (state == RUN_LSR) lsr_q <= rdata;
      if (state == RUN_RBR) rx_data <= rdata;
      rx_valid <= (state == RUN_RBR);
      if (accept_start) cfg_done <= 1'b0;
      else if (state_d == RUN_LSR) cfg_done <= 1'b1;
      cs    <= cs_d;
      wr    <= wr_d;
      rd    <= cs_d & ~wr_d;
      addr  <= addr_d;
      wdata <= wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_host_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_host_master
// Brief    : Self-checking bench for uart_host_master with a behavioural
//            16550 register model (RX FIFO, THRE flag) and access log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_host_master;

  typedef struct {
    int         cyc;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic       done;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] divisor = 16'h0000;
  logic [7:0]  lcr_cfg = 8'h00;
  logic [7:0]  fcr_cfg = 8'h00;
  logic [7:0]  ier_cfg = 8'h00;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready;
  logic        rx_ready = 1'b0;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cs;
  logic        wr;
  logic        rd;
  logic [2:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        cfg_done;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int proto_viol = 0;

  // UART register model: RX FIFO drives DR, thre_en drives THRE
  logic [7:0] rx_mem [0:255];
  int         rx_wp = 0;
  int         rx_rp = 0;
  logic       thre_en = 1'b0;
  logic [7:0] lsr_noise = 8'h00;
  logic       dr;
  logic [7:0] lsr_val;

  acc_t       log_q [$];
  int         rxv_cyc [$];
  logic [7:0] rxv_dat [$];
  int         txr_cyc [$];
  acc_t       mon_e;
  logic       prev_cs = 1'b0;
  logic       prev_rxv = 1'b0;

  uart_host_master dut (
    .clk(clk), .rst(rst), .start(start), .divisor(divisor),
    .lcr_cfg(lcr_cfg), .fcr_cfg(fcr_cfg), .ier_cfg(ier_cfg),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .cs(cs), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dr      = (rx_wp != rx_rp);
  assign lsr_val = (lsr_noise & 8'hDE) | {2'b00, thre_en, 4'b0000, dr};

  always_comb begin
    rdata = 8'h00;
    if (cs && !wr) begin
      if (addr == 3'd5) rdata = lsr_val;
      else if (addr == 3'd0) rdata = dr ? rx_mem[rx_rp[7:0]] : 8'hEE;
    end
  end

  // Reading RBR pops the FIFO
  always @(posedge clk) begin
    if (cs && !wr && addr == 3'd0 && dr) rx_rp <= rx_rp + 1;
  end

  // Access log and protocol watch, sampled mid-cycle
  always @(negedge clk) begin
    #2;
    if (cs) begin
      mon_e.cyc  = cyc;
      mon_e.wr   = wr;
      mon_e.addr = addr;
      mon_e.data = wr ? wdata : rdata;
      mon_e.done = cfg_done;
      log_q.push_back(mon_e);
    end
    if (rd !== (cs & !wr)) proto_viol++;
    if (cs && prev_cs) proto_viol++;
    if (rx_valid && prev_rxv) proto_viol++;
    if (cs && !wr && addr == 3'd0 && !dr) proto_viol++;
    if (rst && tx_ready) proto_viol++;
    if (tx_ready) txr_cyc.push_back(cyc);
    if (rx_valid) begin
      rxv_cyc.push_back(cyc);
      rxv_dat.push_back(rx_data);
    end
    prev_cs  = cs;
    prev_rxv = rx_valid;
  end

  function automatic bit has_acc(input int c, input logic w, input logic [2:0] a);
    has_acc = 1'b0;
    foreach (log_q[k])
      if (log_q[k].cyc == c && log_q[k].wr == w && log_q[k].addr == a) has_acc = 1'b1;
  endfunction

  task automatic pulse_start(input logic [15:0] d, input logic [7:0] l, f, i, output int sc);
    @(negedge clk);
    divisor = d; lcr_cfg = l; fcr_cfg = f; ier_cfg = i; start = 1'b1;
    sc = cyc;
    @(negedge clk);
    start = 1'b0;
    divisor = 16'($urandom); lcr_cfg = 8'($urandom);
    fcr_cfg = 8'($urandom);  ier_cfg = 8'($urandom);
  endtask

  // Expected: six writes every other cycle from sc+1, then the first LSR read
  // at sc+13 carrying cfg_done=1.
  task automatic check_config(input int sc, input logic [15:0] d, input logic [7:0] l, f, i);
    logic [2:0] ea [7];
    logic [7:0] ed [7];
    acc_t       got [$];
    int         t;
    ea[0] = 3'd3; ed[0] = l | 8'h80;
    ea[1] = 3'd0; ed[1] = d[7:0];
    ea[2] = 3'd1; ed[2] = d[15:8];
    ea[3] = 3'd3; ed[3] = l & 8'h7F;
    ea[4] = 3'd2; ed[4] = f;
    ea[5] = 3'd1; ed[5] = i;
    ea[6] = 3'd5; ed[6] = 8'h00;
    t = 0;
    while (cyc < sc + 15 && t < 40) begin @(negedge clk); t++; end
    #3;
    foreach (log_q[k]) if (log_q[k].cyc > sc && log_q[k].cyc <= sc + 13) got.push_back(log_q[k]);
    vectors++;
    if (got.size() != 7) begin
      errors++;
      $display("FAIL cfg_count: %0d accesses after start, required 7", got.size());
    end
    for (int k = 0; k < 7 && k < got.size(); k++) begin
      vectors++;
      if (got[k].cyc !== sc + 1 + 2 * k || got[k].addr !== ea[k] || got[k].wr !== (k < 6) ||
          (k < 6 && got[k].data !== ed[k]) || got[k].done !== (k == 6)) begin
        errors++;
        $display("FAIL cfg_access[%0d]: got cyc=%0d wr=%0b addr=%0d data=%02h done=%0b, required cyc=%0d wr=%0b addr=%0d data=%02h done=%0b",
                 k, got[k].cyc, got[k].wr, got[k].addr, got[k].data, got[k].done,
                 sc + 1 + 2 * k, (k < 6), ea[k], ed[k], (k == 6));
      end
    end
  endtask

  task automatic test_reset();
    int l0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({cs, wr, rd, addr, wdata} !== 14'd0) begin
      errors++;
      $display("FAIL reset_bus: cs=%0b wr=%0b rd=%0b addr=%0d wdata=%02h, required all 0", cs, wr, rd, addr, wdata);
    end
    vectors++;
    if ({tx_ready, rx_valid, rx_data} !== 10'd0) begin
      errors++;
      $display("FAIL reset_stream: tx_ready=%0b rx_valid=%0b rx_data=%02h, required all 0", tx_ready, rx_valid, rx_data);
    end
    vectors++;
    if (cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_cfg_done: got %0b, required 0", cfg_done);
    end
    @(negedge clk);
    rst = 1'b0;
    l0 = log_q.size();
    repeat (10) @(negedge clk);
    #3;
    vectors++;
    if (log_q.size() != l0) begin
      errors++;
      $display("FAIL idle_quiet: %0d accesses in IDLE, required 0", log_q.size() - l0);
    end
  endtask

  task automatic test_config();
    logic [15:0] d;
    logic [7:0]  l, f, i;
    int          sc;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        d = 16'h0145; l = 8'h03; f = 8'h07; i = 8'h01;
      end else begin
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        d = 16'($urandom); l = 8'($urandom); f = 8'($urandom); i = 8'($urandom);
      end
      lsr_noise = 8'($urandom);
      pulse_start(d, l, f, i, sc);
      check_config(sc, d, l, f, i);
    end
  endtask

  task automatic test_rx();
    logic [7:0] exp_q [$];
    logic [7:0] b;
    int l0, r0, n_rbr, n_lsr, t, bad;
    l0 = log_q.size(); r0 = rxv_dat.size();
    thre_en = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b = (k == 0) ? 8'h5A : 8'($urandom);
      exp_q.push_back(b);
      rx_mem[rx_wp[7:0]] = b;
      rx_wp++;
    end
    repeat (40) @(negedge clk);
    #3;
    n_rbr = 0; n_lsr = 0;
    for (int k = l0; k < log_q.size(); k++) begin
      if (!log_q[k].wr && log_q[k].addr == 3'd0) n_rbr++;
      if (!log_q[k].wr && log_q[k].addr == 3'd5) n_lsr++;
    end
    vectors++;
    if (n_rbr != 0 || n_lsr < 18) begin
      errors++;
      $display("FAIL rx_blocked: %0d RBR / %0d LSR reads, required 0 / >=18", n_rbr, n_lsr);
    end
    l0 = log_q.size();
    t = 0;
    while (rx_rp != rx_wp && t < 400) begin
      @(negedge clk);
      rx_ready = ($urandom_range(0, 3) != 0);
      t++;
    end
    repeat (4) @(negedge clk);
    #3;
    vectors++;
    if (t >= 400) begin errors++; $display("FAIL rx_timeout: %0d bytes left, required 0", rx_wp - rx_rp); end
    n_rbr = 0;
    for (int k = l0; k < log_q.size(); k++) if (!log_q[k].wr && log_q[k].addr == 3'd0) n_rbr++;
    vectors++;
    if (n_rbr != 6 || rxv_dat.size() - r0 != 6) begin
      errors++;
      $display("FAIL rx_count: %0d RBR reads / %0d rx_valid pulses, required 6 / 6", n_rbr, rxv_dat.size() - r0);
    end
    for (int k = 0; k < 6 && r0 + k < rxv_dat.size(); k++) begin
      vectors++;
      if (rxv_dat[r0 + k] !== exp_q[k]) begin
        errors++;
        $display("FAIL rx_data[%0d]: got %02h, required %02h", k, rxv_dat[r0 + k], exp_q[k]);
      end
    end
    bad = 0;
    for (int k = r0; k < rxv_cyc.size(); k++) if (!has_acc(rxv_cyc[k] - 1, 1'b0, 3'd0)) bad++;
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL rx_valid_timing: %0d pulses not after an RBR read, required 0", bad); end
  endtask

  task automatic test_tx();
    logic [7:0] src [6];
    logic [7:0] got [$];
    int l0, t0, idx, t, bad;
    bit hs;
    l0 = log_q.size(); t0 = txr_cyc.size();
    thre_en = 1'b0; rx_ready = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h3C;
    repeat (30) @(negedge clk);
    #3;
    bad = 0;
    for (int k = l0; k < log_q.size(); k++) if (log_q[k].wr) bad++;
    vectors++;
    if (txr_cyc.size() != t0 || bad != 0) begin
      errors++;
      $display("FAIL tx_blocked: %0d tx_ready / %0d writes with THRE=0, required 0 / 0", txr_cyc.size() - t0, bad);
    end
    for (int k = 0; k < 6; k++) src[k] = (k == 0) ? 8'hA5 : 8'($urandom);
    l0 = log_q.size(); t0 = txr_cyc.size();
    thre_en = 1'b1; hs = 1'b0; idx = 0; t = 0;
    while (idx < 6 && t < 400) begin
      @(negedge clk);
      t++;
      if (hs) idx++;
      if (idx < 6) begin
        tx_data  = src[idx];
        tx_valid = ($urandom_range(0, 2) != 0);
      end else begin
        tx_valid = 1'b0;
      end
      #1;
      hs = tx_valid && tx_ready;
    end
    tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    vectors++;
    if (t >= 400) begin errors++; $display("FAIL tx_timeout: %0d bytes sent, required 6", idx); end
    for (int k = l0; k < log_q.size(); k++)
      if (log_q[k].wr && log_q[k].addr == 3'd0) got.push_back(log_q[k].data);
    vectors++;
    if (got.size() != 6 || txr_cyc.size() - t0 != 6) begin
      errors++;
      $display("FAIL tx_count: %0d THR writes / %0d tx_ready, required 6 / 6", got.size(), txr_cyc.size() - t0);
    end
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      vectors++;
      if (got[k] !== src[k]) begin
        errors++;
        $display("FAIL tx_data[%0d]: got %02h, required %02h", k, got[k], src[k]);
      end
    end
    bad = 0;
    for (int k = t0; k < txr_cyc.size(); k++)
      if (!has_acc(txr_cyc[k] - 1, 1'b0, 3'd5) || !has_acc(txr_cyc[k] + 1, 1'b1, 3'd0)) bad++;
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL tx_ready_timing: %0d misplaced pulses, required 0", bad); end
  endtask

  task automatic test_both();
    logic [7:0] rb, tb_byte;
    int  c, t, t0, r0;
    bit  found, hs;
    thre_en = 1'b1; rx_ready = 1'b1; tx_valid = 1'b0;
    rb = 8'($urandom); tb_byte = 8'($urandom);
    found = 1'b0; t = 0;
    while (!found && t < 20) begin
      @(negedge clk); #1; t++;
      if (cs && !wr && addr == 3'd5) found = 1'b1;
    end
    c = cyc;
    t0 = txr_cyc.size(); r0 = rxv_dat.size();
    rx_mem[rx_wp[7:0]] = rb; rx_wp++;
    tx_data = tb_byte; tx_valid = 1'b1;
    hs = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (hs) tx_valid = 1'b0;
      #1;
      hs = tx_valid && tx_ready;
    end
    tx_valid = 1'b0;
    #3;
    vectors++;
    if (!found) begin errors++; $display("FAIL both_sync: no LSR read seen, required one"); end
    vectors++;
    if (!has_acc(c + 2, 1'b0, 3'd0) || !has_acc(c + 4, 1'b0, 3'd5) || !has_acc(c + 6, 1'b1, 3'd0)) begin
      errors++;
      $display("FAIL both_order: RBR@+2=%0b LSR@+4=%0b THR@+6=%0b, required 1 1 1",
               has_acc(c + 2, 1'b0, 3'd0), has_acc(c + 4, 1'b0, 3'd5), has_acc(c + 6, 1'b1, 3'd0));
    end
    vectors++;
    if (txr_cyc.size() - t0 != 1 || (txr_cyc.size() > t0 && txr_cyc[t0] != c + 5)) begin
      errors++;
      $display("FAIL both_tx_ready: %0d pulses (first at +%0d), required 1 at +5",
               txr_cyc.size() - t0, (txr_cyc.size() > t0) ? txr_cyc[t0] - c : -1);
    end
    vectors++;
    if (rxv_dat.size() - r0 != 1 || (rxv_dat.size() > r0 && rxv_dat[r0] !== rb)) begin
      errors++;
      $display("FAIL both_rx: %0d pulses, required 1 carrying %02h", rxv_dat.size() - r0, rb);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    logic [7:0]  l, f, i;
    int sc, l0, t;
    thre_en = 1'b0; tx_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    d = 16'($urandom); l = 8'($urandom); f = 8'($urandom); i = 8'($urandom);
    pulse_start(d, l, f, i, sc);
    t = 0;
    while (cyc < sc + 4 && t < 10) begin @(negedge clk); t++; end
    rst = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({cs, wr, rd, addr, wdata, tx_ready, rx_valid, rx_data, cfg_done} !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: cs=%0b wr=%0b addr=%0d wdata=%02h cfg_done=%0b, required all 0",
               cs, wr, addr, wdata, cfg_done);
    end
    rst = 1'b0;
    l0 = log_q.size();
    repeat (20) @(negedge clk);
    #3;
    vectors++;
    if (log_q.size() != l0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d accesses after reset, required 0", log_q.size() - l0);
    end
    d = 16'($urandom); l = 8'($urandom); f = 8'($urandom); i = 8'($urandom);
    pulse_start(d, l, f, i, sc);
    check_config(sc, d, l, f, i);
  endtask

  task automatic test_restart();
    logic [15:0] d;
    logic [7:0]  l, f, i;
    int  t, c;
    bit  found;
    thre_en = 1'b0; tx_valid = 1'b0;
    found = 1'b0; t = 0;
    while (!found && t < 20) begin
      @(negedge clk); #1; t++;
      if (cs && !wr && addr == 3'd5) found = 1'b1;
    end
    c = cyc;
    vectors++;
    if (!found) begin errors++; $display("FAIL restart_sync: no LSR read seen, required one"); end
    d = 16'($urandom); l = 8'($urandom); f = 8'($urandom); i = 8'($urandom);
    divisor = d; lcr_cfg = l; fcr_cfg = f; ier_cfg = i;
    start = 1'b1;             // held through the LSR access (ignored) and the decision gap
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    divisor = 16'($urandom); lcr_cfg = 8'($urandom);
    check_config(c + 1, d, l, f, i);
  endtask

  task automatic test_protocol();
    vectors++;
    if (proto_viol !== 0) begin
      errors++;
      $display("FAIL protocol: %0d bus/stream rule violations, required 0", proto_viol);
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_rx();
    test_tx();
    test_both();
    test_reset_mid();
    test_restart();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
